// File: rtl/intensity_pwm_pkg.sv
// intensity_pwm_pkg: shared ramp state, level type and level limit
package intensity_pwm_pkg;
  localparam int MAX_LEVEL = 7;
  typedef logic [2:0] level_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_t;
  function automatic level_t sat_level(input logic [3:0] raw);
    return raw > 4'(MAX_LEVEL) ? level_t'(MAX_LEVEL) : raw[2:0];
  endfunction
endpackage

// File: rtl/intensity_pwm_pwm_gen.sv
// pwm_gen: free-running PWM with duty latched once per period
module pwm_gen
  import intensity_pwm_pkg::*;
#(
  parameter int PWM_PERIOD = 4000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  level_t level,
  output logic   pwm
);
  localparam int CW = $clog2(PWM_PERIOD);
  localparam logic [CW-1:0] STEP = CW'(PWM_PERIOD / 8);
  logic [CW-1:0] cnt, duty, duty_now;
  logic wrap;
  assign wrap = cnt == CW'(PWM_PERIOD - 1);
  // a new duty is only taken at the period start so a period never mixes two levels
  assign duty_now = cnt == '0 ? CW'(level) * STEP : duty;
  // period counter, duty latch and registered compare; enable gates the output directly
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      duty <= duty_now;
      pwm  <= enable && cnt < duty_now;
    end
endmodule

// File: rtl/intensity_pwm.sv
// intensity_pwm: debounced intensity target, one-step-per-tick ramp, PWM drive
module intensity_pwm
  import intensity_pwm_pkg::*;
#(
  parameter int SAMPLE_DIV   = 40000,
  parameter int STABLE_COUNT = 3,
  parameter int PWM_PERIOD   = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] intensity,
  input  logic       enable,
  output logic       pwm,
  output logic [2:0] level,
  output logic       ramping
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [SW-1:0] SC = SW'(STABLE_COUNT);
  logic [TW-1:0] tcnt;
  logic tick, lt, gt;
  level_t sample, candidate, target, eff_target;
  logic [SW-1:0] stable_cnt, stable_nxt;
  ramp_t state;
  assign tick       = tcnt == TW'(SAMPLE_DIV - 1);
  assign sample     = sat_level(intensity);
  assign stable_nxt = sample != candidate ? SW'(1) : stable_cnt == SC ? SC : stable_cnt + SW'(1);
  assign eff_target = enable ? target : '0;
  assign lt         = level < eff_target;
  assign gt         = level > eff_target;
  assign ramping    = state != IDLE;
  // sample-rate divider
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + TW'(1);
  // debounce: target follows the sample once it has been seen STABLE_COUNT ticks in a row
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      candidate  <= '0;
      stable_cnt <= '0;
      target     <= '0;
    end else if (tick) begin
      candidate  <= sample;
      stable_cnt <= stable_nxt;
      if (stable_nxt == SC) target <= sample;
    end
  // ramp FSM: direction re-evaluated every cycle, level moves one step per tick and never passes the target
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      level <= '0;
    end else begin
      state <= lt ? UP : gt ? DOWN : IDLE;
      if (tick && state == UP && lt) level <= level + 3'd1;
      else if (tick && state == DOWN && gt) level <= level - 3'd1;
    end
  pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .level (level),
    .pwm   (pwm)
  );
endmodule

// File: tb/tb_intensity_pwm.sv
// tb_intensity_pwm: scoreboard bench with a tick-level reference model
module tb_intensity_pwm;
  localparam int SD = 10, SC = 3, PP = 16;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [3:0] intensity = '0;
  logic pwm, ramping;
  logic [2:0] level;
  intensity_pwm #(.SAMPLE_DIV(SD), .STABLE_COUNT(SC), .PWM_PERIOD(PP)) dut (
    .clk(clk), .reset(reset), .intensity(intensity), .enable(enable),
    .pwm(pwm), .level(level), .ramping(ramping)
  );
  always #5 clk = ~clk;
  int cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  int tests, fails;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  typedef struct {
    int due;
    int lvl;
    bit ramp;
    bit chk_cnt;
    int cnt;
    bit chk_zero;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit hist[PP];
  int highs;
  // monitor: keeps the last PWM period of samples, compares whenever an expectation falls due
  always @(negedge clk) begin
    for (int i = PP - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pwm;
    if (!reset && q.size() > 0 && cyc >= q[0].due) begin
      cur = q.pop_front();
      check("level", level, cur.lvl);
      check("ramping", ramping, cur.ramp);
      if (cur.chk_cnt) begin
        highs = 0;
        for (int i = 0; i < PP; i++) highs += hist[i];
        check("pwm_high_per_period", highs, cur.cnt);
      end
      if (cur.chk_zero) check("pwm_disabled", pwm, 0);
    end
  end
  int tgt, lvl, k;
  int smp[$];
  int lvh[$];
  bit en_prev;
  task automatic model_reset();
    tgt = 0; lvl = 0; k = 0; en_prev = 0;
    smp.delete();
    lvh.delete();
  endtask
  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  // one sample period: drive inputs mid-period, predict the state after the coming tick
  task automatic slot(input int in, input bit en);
    exp_t e;
    int s, eff;
    bit same, flat, dropped;
    wait_neg(SD * k + 5);
    intensity = 4'(in);
    enable = en;
    k++;
    s = in > 7 ? 7 : in;
    eff = en ? tgt : 0;
    if (lvl < eff) lvl++;
    else if (lvl > eff) lvl--;
    smp.push_back(s);
    if (smp.size() > SC) void'(smp.pop_front());
    same = 1;
    foreach (smp[i]) if (smp[i] != s) same = 0;
    if (smp.size() == SC && same) tgt = s;
    lvh.push_back(lvl);
    if (lvh.size() > 4) void'(lvh.pop_front());
    flat = lvh.size() == 4;
    foreach (lvh[i]) if (lvh[i] != lvl) flat = 0;
    e.due = SD * k + 2;
    e.lvl = lvl;
    e.ramp = lvl != (en ? tgt : 0);
    e.chk_cnt = en && en_prev && flat;
    e.cnt = lvl * PP / 8;
    e.chk_zero = !en;
    q.push_back(e);
    dropped = en_prev && !en;
    en_prev = en;
    if (dropped) begin
      @(negedge clk);
      check("pwm_off_next_edge", pwm, 0);
    end
  endtask
  task automatic mid_reset();
    wait_neg(SD * k + 5);
    #3 reset = 1'b1;
    #1;
    check("rst_now_level", level, 0);
    check("rst_now_ramping", ramping, 0);
    check("rst_now_pwm", pwm, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_level", level, 0);
    check("rst_hold_pwm", pwm, 0);
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", fails);
    $fatal(1);
  end
  initial begin
    int in, hold;
    bit en;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_level", level, 0);
    check("reset_ramping", ramping, 0);
    check("reset_pwm", pwm, 0);
    reset = 1'b0;
    repeat (13) slot(5, 1);
    repeat (10) slot(4, 1);
    repeat (6) slot(12, 1);
    repeat (6) slot(7, 1);
    repeat (12) slot(1, 1);
    repeat (10) slot(6, 1);
    repeat (10) slot(6, 0);
    repeat (10) slot(6, 1);
    repeat (12) slot(0, 1);
    for (int i = 0; i < 8; i++) slot(i % 2 ? 6 : 2, 1);
    while (lvl != 3) slot(7, 1);
    mid_reset();
    repeat (10) slot(5, 1);
    for (int i = 0; i < 60; i++) begin
      in = $urandom_range(0, 15);
      en = $urandom_range(0, 9) != 0;
      hold = $urandom_range(1, 5);
      repeat (hold) slot(in, en);
    end
    wait_neg(SD * k + 5);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/intensity_pwm.md
INTENSITY_PWM -- requirements
Module: intensity_pwm

Interface
REQ-001 Parameter SAMPLE_DIV, default 40000, clk cycles per sample tick (1 ms at 40 MHz).
REQ-002 Parameter STABLE_COUNT, default 3, consecutive equal samples required before the target updates.
REQ-003 Parameter PWM_PERIOD, default 4000, clk cycles per PWM period (10 kHz); SHALL be a multiple of 8.
REQ-004 Port clk  in  1  40 MHz system clock.
REQ-005 Port reset  in  1  reset, asynchronous, active-high.
REQ-006 Port intensity  in  4  raw level from the distance stage; 0 = far/none, 7 = closest.
REQ-007 Port enable  in  1  output enable; low forces the target to 0.
REQ-008 Port pwm  out  1  PWM drive for the actuator.
REQ-009 Port level  out  3  current ramped level, 0..7.
REQ-010 Port ramping  out  1  high while level != target.

Function
REQ-011 Tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; tick SHALL pulse for one cycle when the count equals SAMPLE_DIV-1.
REQ-012 On tick, intensity SHALL be sampled; values 8..15 SHALL saturate to 7.
REQ-013 Sample equal to candidate: stable_cnt increments, saturating at STABLE_COUNT; sample differs: candidate <= sample, stable_cnt <= 1.
REQ-014 When stable_cnt equals STABLE_COUNT on a tick, target SHALL load candidate (first update exactly STABLE_COUNT ticks after a step input).
REQ-015 When enable is low, target SHALL be 0 regardless of the filter; filter state keeps running.
REQ-016 Ramp FSM states: IDLE (level == target), UP (level < target), DOWN (level > target); state is evaluated every cycle.
REQ-017 In UP, level SHALL increment by 1 per tick; in DOWN, level SHALL decrement by 1 per tick; in IDLE, level holds.
REQ-018 A target change mid-ramp SHALL redirect the ramp on the next tick without overshoot; level never passes target.
REQ-019 Target update and level step on the same tick: the level step SHALL use the pre-update target.
REQ-020 ramping SHALL be high in UP and DOWN and low in IDLE.
REQ-021 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap.
REQ-022 duty SHALL be latched as level*(PWM_PERIOD/8) only when the PWM counter is 0; mid-period level changes SHALL not glitch the current period.
REQ-023 pwm SHALL be registered and high when pwm_cnt < duty_latched; level 0 gives constant low, level 7 gives 7/8 duty.
REQ-024 enable low SHALL force pwm low on the next clk edge, independent of the ramp.
REQ-025 All arithmetic SHALL be unsigned; the counter widths SHALL be $clog2 of their terminal values; duty SHALL be wide enough for 7*PWM_PERIOD/8.

Reset
REQ-026 Reset SHALL asynchronously clear the tick and PWM counters, candidate, stable_cnt, target, level, and duty_latched to 0, and set the FSM to IDLE.
REQ-027 During and after reset, pwm, level, and ramping SHALL be 0.
REQ-028 Reset asserted mid-ramp or mid-period SHALL take effect immediately; after release, operation restarts with the first tick SAMPLE_DIV cycles later.

Structure
REQ-029 A shared package SHALL hold the ramp-state enum {IDLE, UP, DOWN}, the MAX_LEVEL=7 constant, and the 3-bit level typedef.
REQ-030 The PWM generator (counter, duty latch, compare) SHALL be a sub-module named pwm_gen, parameterised by PWM_PERIOD; the filter and ramp SHALL stay in intensity_pwm.

Verification (SAMPLE_DIV=10, STABLE_COUNT=3, PWM_PERIOD=16)
REQ-031 Reset release with intensity=5, enable=1: target=5 after tick 3; level steps 1..5 on ticks 4..8; ramping high on ticks 3..7, then low.
REQ-032 level=4 steady: pwm high 8 of every 16 cycles; level=7: high 14/16; level=0: pwm never high.
REQ-033 Alternate intensity 2/6 every tick from level 0: target never changes and level stays 0.
REQ-034 Target 7 reached, then intensity=1 held: level ramps down one per tick to 1; no overshoot below 1.
REQ-035 enable dropped while level=6: pwm low on the next edge; level ramps down to 0; restoring enable ramps back up to the filtered target.
REQ-036 Reset asserted mid-ramp at level=3 and mid-PWM-period: all outputs 0 immediately; after release, recovery matches REQ-031.
